// File: rtl/blocpu_program_loader.sv
// Framed byte-stream loader for blocpu_core: assembles instruction words, writes them into
// instruction memory, then requests the core to run and tracks it until it halts.
module blocpu_program_loader #(
    parameter int unsigned InstrWidth   = 12,
    parameter int unsigned AddrWidth    = 8,
    parameter logic [7:0]  SyncByte     = 8'hB1,
    parameter int unsigned StartTimeout = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [7:0]            in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  mem_we_o,
    output logic [AddrWidth-1:0]  mem_addr_o,
    output logic [InstrWidth-1:0] mem_wdata_o,
    output logic                  core_run_o,
    input  logic                  core_running_i,
    output logic                  busy_o,
    output logic [1:0]            load_error_o,
    output logic [AddrWidth-1:0]  loaded_count_o
);

    localparam int unsigned TmoW = $clog2(StartTimeout + 1);

    typedef enum logic [2:0] {
        StIdle, StLen, StLo, StHi, StWrite, StCsum, StStart, StWaitRun
    } state_e;

    state_e                  state_q, state_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              lo_q, lo_d;
    logic [7:0]              csum_q, csum_d;
    logic [InstrWidth-1:0]   word_q, word_d;
    logic [AddrWidth-1:0]    addr_q, addr_d;
    logic [AddrWidth-1:0]    count_q, count_d;
    logic [1:0]              err_q, err_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;

    logic                    accept;
    logic                    hi_bad;
    logic [15:0]             word_full;
    logic [AddrWidth-1:0]    count_inc;

    assign in_ready_o     = !(state_q inside {StWrite, StStart, StWaitRun});
    assign accept         = in_valid_i && in_ready_o;
    assign word_full      = {in_data_i, lo_q};
    // HI may only carry the InstrWidth-8 upper instruction bits.
    assign hi_bad         = (in_data_i >> (InstrWidth - 8)) != 8'd0;
    assign count_inc      = count_q + 1'b1;

    assign mem_we_o       = (state_q == StWrite);
    assign mem_addr_o     = addr_q;
    assign mem_wdata_o    = word_q;
    assign core_run_o     = (state_q == StStart) || (state_q == StWaitRun);
    assign busy_o         = (state_q != StIdle);
    assign load_error_o   = err_q;
    assign loaded_count_o = count_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        lo_d    = lo_q;
        csum_d  = csum_q;
        word_d  = word_q;
        addr_d  = addr_q;
        count_d = count_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (accept && in_data_i == SyncByte) begin
                    state_d = StLen;
                    err_d   = 2'd0;
                    count_d = '0;
                    addr_d  = '0;
                    csum_d  = 8'd0;
                end
            end
            StLen: begin
                if (accept) begin
                    if (in_data_i == 8'd0) begin
                        err_d   = 2'd1;
                        state_d = StIdle;
                    end else begin
                        len_d   = in_data_i;
                        csum_d  = csum_q ^ in_data_i;
                        state_d = StLo;
                    end
                end
            end
            StLo: begin
                if (accept) begin
                    lo_d    = in_data_i;
                    csum_d  = csum_q ^ in_data_i;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (accept) begin
                    if (hi_bad) begin
                        err_d   = 2'd1;
                        state_d = StIdle;
                    end else begin
                        word_d  = word_full[InstrWidth-1:0];
                        csum_d  = csum_q ^ in_data_i;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_inc;
                state_d = (count_inc == AddrWidth'(len_q)) ? StCsum : StLo;
            end
            StCsum: begin
                if (accept) begin
                    if (in_data_i == csum_q) begin
                        tmo_d   = '0;
                        state_d = StStart;
                    end else begin
                        err_d   = 2'd2;
                        state_d = StIdle;
                    end
                end
            end
            StStart: begin
                if (core_running_i) begin
                    state_d = StWaitRun;
                end else if (tmo_q == TmoW'(StartTimeout - 1)) begin
                    err_d   = 2'd3;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitRun: begin
                // Entered only with core_running high, so a low here is the falling edge.
                if (!core_running_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            len_q   <= 8'd0;
            lo_q    <= 8'd0;
            csum_q  <= 8'd0;
            word_q  <= '0;
            addr_q  <= '0;
            count_q <= '0;
            err_q   <= 2'd0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: tb/tb_blocpu_program_loader.sv
// Directed bench for blocpu_program_loader: frames, error paths, run handshake and reset.
module tb_blocpu_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [11:0] mem_wdata;
    logic        core_run;
    logic        core_running = 1'b0;
    logic        busy;
    logic [1:0]  load_error;
    logic [7:0]  loaded_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  frm[$];
    logic [7:0]  wr_addr[$];
    logic [11:0] wr_data[$];
    int          run_cycles = 0;

    blocpu_program_loader dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .core_run_o     (core_run),
        .core_running_i (core_running),
        .busy_o         (busy),
        .load_error_o   (load_error),
        .loaded_count_o (loaded_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (core_run) run_cycles = run_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        run_cycles = 0;
    endtask

    // Called at a negedge; returns at a negedge after the byte has been taken.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) @(negedge clk);
    endtask

    task automatic send_frame(input int gap);
        foreach (frm[i]) send_byte(frm[i], gap);
    endtask

    task automatic check_good_writes(input string tag);
        logic [31:0] a, d;
        check({tag, "_nwr"}, wr_addr.size(), 2);
        for (int i = 0; i < 2; i++) begin
            a = (i < wr_addr.size()) ? 32'(wr_addr[i]) : 32'hDEAD;
            d = (i < wr_data.size()) ? 32'(wr_data[i]) : 32'hDEAD;
            check($sformatf("%s_addr%0d", tag, i), a, i);
            check($sformatf("%s_data%0d", tag, i), d, (i == 0) ? 32'h12A : 32'h201);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_run", core_run, 0);
        check("rst_busy", busy, 0);
        check("rst_err", load_error, 0);
        check("rst_count", loaded_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame preceded by garbage, then a run handshake.
        clear_log();
        frm = '{8'h00, 8'hFF, 8'hB1, 8'h02, 8'h2A, 8'h01, 8'h01, 8'h02, 8'h2A};
        send_frame(0);
        check_good_writes("good");
        check("good_count", loaded_count, 2);
        check("good_run", core_run, 1);
        check("good_start_ready", in_ready, 0);
        core_running = 1'b1;
        in_data  = 8'hB1;
        in_valid = 1'b1;
        idle_cycles(3);
        check("wait_ready", in_ready, 0);
        check("wait_run", core_run, 1);
        in_valid = 1'b0;
        idle_cycles(7);
        core_running = 1'b0;
        idle_cycles(2);
        check("halt_run", core_run, 0);
        check("halt_busy", busy, 0);
        check("halt_err", load_error, 0);
        check("halt_count", loaded_count, 2);

        // Bad checksum.
        clear_log();
        frm = '{8'hB1, 8'h02, 8'h2A, 8'h01, 8'h01, 8'h02, 8'h2B};
        send_frame(0);
        idle_cycles(5);
        check_good_writes("badcs");
        check("badcs_err", load_error, 2);
        check("badcs_runcyc", run_cycles, 0);
        check("badcs_busy", busy, 0);

        // Zero length.
        clear_log();
        frm = '{8'hB1, 8'h00};
        send_frame(0);
        idle_cycles(2);
        check("len0_err", load_error, 1);
        check("len0_nwr", wr_addr.size(), 0);
        check("len0_busy", busy, 0);

        // HI byte with bits above the instruction width.
        clear_log();
        frm = '{8'hB1, 8'h01, 8'h55, 8'h13};
        send_frame(0);
        idle_cycles(2);
        check("hibad_err", load_error, 1);
        check("hibad_nwr", wr_addr.size(), 0);
        check("hibad_busy", busy, 0);

        // Start timeout with the core never responding.
        clear_log();
        frm = '{8'hB1, 8'h02, 8'h2A, 8'h01, 8'h01, 8'h02, 8'h2A};
        send_frame(0);
        check("tmo_err_pending", load_error, 0);
        idle_cycles(30);
        check("tmo_runcyc", run_cycles, 16);
        check("tmo_err", load_error, 3);
        check("tmo_run", core_run, 0);
        check_good_writes("tmo");

        // Same frame with in_valid low every other cycle.
        clear_log();
        send_frame(1);
        check("bp_err_clr", load_error, 0);
        check_good_writes("bp");
        check("bp_count", loaded_count, 2);
        check("bp_run", core_run, 1);
        core_running = 1'b1;
        idle_cycles(3);
        core_running = 1'b0;
        idle_cycles(2);
        check("bp_halt_busy", busy, 0);

        // Asynchronous reset after the first LO byte, then a fresh load.
        clear_log();
        frm = '{8'hB1, 8'h02, 8'h2A};
        send_frame(0);
        check("mid_busy_pre", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_wdata", mem_wdata, 0);
        check("mid_addr", mem_addr, 0);
        check("mid_ready", in_ready, 1);
        check("mid_err", load_error, 0);
        check("mid_count", loaded_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        frm = '{8'hB1, 8'h02, 8'h2A, 8'h01, 8'h01, 8'h02, 8'h2A};
        send_frame(0);
        check_good_writes("after_rst");
        check("after_rst_run", core_run, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/blocpu_program_loader.md
Name: blocpu_program_loader

Overview:
Upstream feeder for blocpu_core. It accepts a framed byte stream (from a UART receiver or a bench driver), assembles 12-bit instructions, and writes them sequentially into the core's instruction memory. After a valid checksum it requests the core to run, then tracks `running` until the core halts. It replaces the direct memory pokes and manual `running` assertion currently done in simulation.

Parameters:
INSTR_WIDTH, 12, instruction word width; must be 9..16.
ADDR_WIDTH, 8, instruction memory address width; maximum program length is 2**ADDR_WIDTH - 1.
SYNC_BYTE, 8'hB1, frame start marker.
START_TIMEOUT, 16, cycles allowed between `core_run` rising and `core_running` rising.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_ready  out  1  loader accepts the byte; transfer occurs when in_valid && in_ready
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  INSTR_WIDTH  write data
core_run  out  1  run request to core, level
core_running  in  1  core's running flag
busy  out  1  high in every state except IDLE
load_error  out  2  0 none, 1 format, 2 checksum, 3 start timeout; sticky until next SYNC_BYTE accepted
loaded_count  out  ADDR_WIDTH  words written in last/current frame

Behaviour:
- Reset (asynchronous assert, synchronous deassert by caller): state IDLE. in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_run=0, busy=0, load_error=0, loaded_count=0, checksum accumulator=0.
- Frame format: SYNC_BYTE, LEN (1..255 words), then LEN pairs {LO, HI}, then CSUM. Word = {HI, LO}[INSTR_WIDTH-1:0]. CSUM = XOR of LEN and every LO/HI byte.
- States and transitions, each advancing only on an accepted byte unless stated otherwise:
  - IDLE: a byte == SYNC_BYTE moves to LEN and clears load_error, loaded_count, mem_addr, and the accumulator. Any other byte is discarded.
  - LEN: LEN==0 sets load_error=1 and returns to IDLE. Otherwise store the length, XOR it into the accumulator, and go to LO.
  - LO: latch the byte, XOR it, go to HI.
  - HI: if HI bits above INSTR_WIDTH-8 are nonzero, set load_error=1 and go to IDLE with no write. Otherwise:
    - next cycle: mem_we=1 for exactly one cycle, with mem_addr = current index and mem_wdata = word;
    - afterwards mem_addr increments and loaded_count increments;
    - go to LO if more words remain, else CSUM.
  - CSUM: a mismatch sets load_error=2 and goes to IDLE; memory contents already written are left as is. A match goes to START.
  - START: in_ready=0, core_run=1, timeout counter starts at 0.
    - core_running=1 goes to WAIT_RUN.
    - Counter reaching START_TIMEOUT: core_run=0, load_error=3, go to IDLE.
  - WAIT_RUN: in_ready=0, core_run held 1. A falling core_running (1 to 0) drops core_run and goes to IDLE the same cycle.
- in_ready is 1 in IDLE, LEN, LO, HI, and CSUM, and 0 in START and WAIT_RUN. It is also 0 during the mem_we cycle, so no byte is accepted while a write is in flight.
- Bytes presented with in_valid=0 are ignored. A stalled stream (in_valid low indefinitely) holds the current state; there is no inter-byte timeout.
- A SYNC_BYTE value appearing inside a frame is data, not a resync.
- LEN=255 with ADDR_WIDTH=8 writes addresses 0..254, and mem_addr never wraps.
- Reset asserted mid-frame or mid-run: immediate return to reset values and core_run=0. Partial memory contents are undefined for the core.

Test Plan:
- Good frame: B1, 02, 2A, 01, 01, 02, 2A. Expect mem_we pulses with (addr 0, 0x12A) and (addr 1, 0x201), loaded_count=2, and core_run rising after CSUM. Drive core_running 1 for 10 cycles then 0; expect core_run=0, state IDLE, load_error=0.
- Bad checksum: same frame with CSUM=0x2B. Expect two writes, load_error=2, and core_run never asserted.
- Format errors:
  - B1, 00: expect load_error=1, no writes.
  - B1, 01, 55, 13: expect load_error=1, no mem_we.
- Start timeout: good frame with core_running held 0. Expect core_run high for exactly START_TIMEOUT cycles, then load_error=3 and core_run=0.
- Backpressure and noise:
  - Garbage bytes 00, FF before B1: expect them discarded.
  - in_valid toggled every other cycle: expect identical writes to the good-frame case.
  - While in WAIT_RUN: expect in_ready=0 and bytes not consumed.
- Reset mid-frame: assert reset low after the first LO byte. Expect all outputs at reset values asynchronously, then a fresh good frame loads correctly.
